// File: rtl/snn_spike_scheduler_if.sv
// Spike-event channel between the scheduler and the synaptic accumulator.
// The master offers an event address; the slave accepts it with ev_ready.
interface snn_spike_scheduler_if #(
  parameter int unsigned AW = 2
);
  logic          ev_valid;
  logic          ev_ready;
  logic [AW-1:0] ev_addr;

  modport master (
    output ev_valid,
    output ev_addr,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_addr,
    output ev_ready
  );
endinterface

// File: rtl/snn_spike_scheduler.sv
// Timestep scheduler: captures the layer-1 spike vector, drains it as round-robin
// address events to the accumulator, then strobes layer-2 update and step completion.
module snn_spike_scheduler #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step_start,
  input  logic [N-1:0]                 spike_in,
  snn_spike_scheduler_if.master        ev,
  output logic                         l2_update,
  output logic                         step_done,
  output logic                         busy,
  output logic [7:0]                   event_count,
  output logic                         overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    UPDATE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  pending;
  logic [N-1:0]  pending_nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic [7:0]    count_nxt;

  logic          found_hi;
  logic          found_lo;
  logic [AW-1:0] idx_hi;
  logic [AW-1:0] idx_lo;
  logic [AW-1:0] grant_idx;
  logic [N-1:0]  grant_mask;
  logic [N-1:0]  pending_left;
  logic          offer;
  logic          accept;

  // Round-robin pick: first set bit at or above ptr, otherwise first set bit from 0.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_hi && pending[i] && (i >= 32'(ptr))) begin
        found_hi = 1'b1;
        idx_hi   = AW'(i);
      end
      if (!found_lo && pending[i]) begin
        found_lo = 1'b1;
        idx_lo   = AW'(i);
      end
    end
    grant_idx = found_hi ? idx_hi : idx_lo;
  end

  assign grant_mask   = {{(N-1){1'b0}}, 1'b1} << grant_idx;
  assign pending_left = pending & ~grant_mask;

  assign offer  = (state == DRAIN) && (|pending);
  assign accept = offer && ev.ev_ready;

  assign ev.ev_valid = offer;
  assign ev.ev_addr  = offer ? grant_idx : '0;
  assign l2_update   = (state == UPDATE);
  assign step_done   = (state == DONE);
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    ptr_nxt     = ptr;
    count_nxt   = event_count;
    unique case (state)
      IDLE: begin
        if (step_start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt   = DRAIN;
        pending_nxt = spike_in;
        count_nxt   = '0;
      end
      DRAIN: begin
        if (!offer) begin
          state_nxt = UPDATE;
        end else if (accept) begin
          pending_nxt = pending_left;
          ptr_nxt     = (grant_idx == AW'(N - 1)) ? '0 : grant_idx + 1'b1;
          if (event_count != '1) count_nxt = event_count + 8'd1;
          // Leave on the last handshake so k events take exactly k DRAIN cycles.
          if (pending_left == '0) state_nxt = UPDATE;
        end
      end
      UPDATE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      ptr         <= '0;
      event_count <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      ptr         <= ptr_nxt;
      event_count <= count_nxt;
      if (step_start && (state != IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snn_spike_scheduler.sv
// Directed bench for snn_spike_scheduler (N=4): vector table of full timesteps
// plus hand-written stall, overrun and mid-drain reset sequences.
module tb_snn_spike_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         step_start;
  logic [N-1:0] spike_in;
  logic         l2_update;
  logic         step_done;
  logic         busy;
  logic [7:0]   event_count;
  logic         overrun;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  snn_spike_scheduler_if #(.AW(AW)) ev_bus ();

  snn_spike_scheduler #(.N(N), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .step_start  (step_start),
    .spike_in    (spike_in),
    .ev          (ev_bus),
    .l2_update   (l2_update),
    .step_done   (step_done),
    .busy        (busy),
    .event_count (event_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]          spikes;
    int unsigned           k;
    logic [3:0][AW-1:0]    addrs;
  } vec_t;

  vec_t vecs [6];
  vec_t v_after_reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(ev_bus.ev_valid), 32'd0);
    check({tag, "_addr"},  32'(ev_bus.ev_addr),  32'd0);
    check({tag, "_l2"},    32'(l2_update),       32'd0);
    check({tag, "_done"},  32'(step_done),       32'd0);
    check({tag, "_busy"},  32'(busy),            32'd0);
    check({tag, "_count"}, 32'(event_count),     32'd0);
    check({tag, "_ovr"},   32'(overrun),         32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full timestep with ev_ready=1; entered and left at #1 after a rising edge, FSM in IDLE.
  task automatic run_vec(input int unsigned id, input vec_t v);
    int unsigned nd;
    nd = (v.k == 0) ? 1 : v.k;
    ev_bus.ev_ready = 1'b1;
    spike_in   = v.spikes;
    step_start = 1'b1;
    check($sformatf("v%0d_idle_busy", id), 32'(busy), 32'd0);
    tick();
    step_start = 1'b0;
    check($sformatf("v%0d_cap_busy", id), 32'(busy), 32'd1);
    check($sformatf("v%0d_cap_valid", id), 32'(ev_bus.ev_valid), 32'd0);
    for (int unsigned i = 0; i < nd; i++) begin
      tick();
      if (i == 0) spike_in = ~v.spikes;
      check($sformatf("v%0d_d%0d_valid", id, i), 32'(ev_bus.ev_valid), (v.k == 0) ? 32'd0 : 32'd1);
      check($sformatf("v%0d_d%0d_addr", id, i), 32'(ev_bus.ev_addr),
            (v.k == 0) ? 32'd0 : 32'(v.addrs[i]));
      check($sformatf("v%0d_d%0d_count", id, i), 32'(event_count), i);
      check($sformatf("v%0d_d%0d_l2", id, i), 32'(l2_update), 32'd0);
    end
    tick();
    check($sformatf("v%0d_upd_l2", id), 32'(l2_update), 32'd1);
    check($sformatf("v%0d_upd_done", id), 32'(step_done), 32'd0);
    check($sformatf("v%0d_upd_valid", id), 32'(ev_bus.ev_valid), 32'd0);
    tick();
    check($sformatf("v%0d_done_strobe", id), 32'(step_done), 32'd1);
    check($sformatf("v%0d_done_l2", id), 32'(l2_update), 32'd0);
    check($sformatf("v%0d_done_count", id), 32'(event_count), v.k);
    tick();
    check($sformatf("v%0d_idle_done", id), 32'(step_done), 32'd0);
    check($sformatf("v%0d_idle_busy2", id), 32'(busy), 32'd0);
    check($sformatf("v%0d_hold_count", id), 32'(event_count), v.k);
  endtask

  initial begin
    // Expected orders follow the carried round-robin pointer (0 after reset).
    vecs[0] = '{spikes: 4'b1011, k: 3, addrs: {2'd0, 2'd3, 2'd1, 2'd0}}; // ptr -> 0
    vecs[1] = '{spikes: 4'b0000, k: 0, addrs: {2'd0, 2'd0, 2'd0, 2'd0}}; // ptr -> 0
    vecs[2] = '{spikes: 4'b0010, k: 1, addrs: {2'd0, 2'd0, 2'd0, 2'd1}}; // ptr -> 2
    vecs[3] = '{spikes: 4'b1011, k: 3, addrs: {2'd0, 2'd1, 2'd0, 2'd3}}; // ptr -> 2
    vecs[4] = '{spikes: 4'b1111, k: 4, addrs: {2'd1, 2'd0, 2'd3, 2'd2}}; // ptr -> 2
    vecs[5] = '{spikes: 4'b0100, k: 1, addrs: {2'd0, 2'd0, 2'd0, 2'd2}}; // ptr -> 3
    v_after_reset = '{spikes: 4'b1111, k: 4, addrs: {2'd3, 2'd2, 2'd1, 2'd0}};

    reset = 1'b1;
    step_start = 1'b1;
    spike_in = 4'b1111;
    ev_bus.ev_ready = 1'b1;
    #12;
    check_all_zero("reset");
    step_start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int unsigned t = 0; t < 6; t++) run_vec(t, vecs[t]);
    check("no_overrun", 32'(overrun), 32'd0);

    // Stall: one event held for three not-ready cycles, accepted on the fourth.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ev_bus.ev_ready = 1'b0;
    spike_in = 4'b0001;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    for (int unsigned c = 0; c < 4; c++) begin
      tick();
      check($sformatf("stall_c%0d_valid", c), 32'(ev_bus.ev_valid), 32'd1);
      check($sformatf("stall_c%0d_addr", c), 32'(ev_bus.ev_addr), 32'd0);
      check($sformatf("stall_c%0d_count", c), 32'(event_count), 32'd0);
      if (c == 3) ev_bus.ev_ready = 1'b1;
    end
    tick();
    check("stall_l2", 32'(l2_update), 32'd1);
    check("stall_count", 32'(event_count), 32'd1);
    tick();
    check("stall_done", 32'(step_done), 32'd1);
    tick();

    // Overrun: step_start pulsed in DRAIN is ignored but flagged; ptr is 1 here.
    ev_bus.ev_ready = 1'b0;
    spike_in = 4'b1111;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick();
    check("ovr_pre_flag", 32'(overrun), 32'd0);
    check("ovr_pre_addr", 32'(ev_bus.ev_addr), 32'd1);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_still_valid", 32'(ev_bus.ev_valid), 32'd1);
    check("ovr_still_addr", 32'(ev_bus.ev_addr), 32'd1);
    ev_bus.ev_ready = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check($sformatf("ovr_e%0d_addr", c), 32'(ev_bus.ev_addr), (c == 2) ? 32'd0 : 32'(c + 2));
    end
    tick();
    check("ovr_l2", 32'(l2_update), 32'd1);
    tick();
    check("ovr_done", 32'(step_done), 32'd1);
    check("ovr_count", 32'(event_count), 32'd4);
    tick();
    run_vec(10, vecs[1]);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-drain after one of three events (ptr 1: order 2,3,0).
    spike_in = 4'b1101;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick();
    check("rd_first_addr", 32'(ev_bus.ev_addr), 32'd2);
    tick();
    check("rd_second_addr", 32'(ev_bus.ev_addr), 32'd3);
    check("rd_count", 32'(event_count), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rd_async");
    tick();
    check_all_zero("rd_held");
    reset = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rd_post%0d_l2", c), 32'(l2_update), 32'd0);
      check($sformatf("rd_post%0d_done", c), 32'(step_done), 32'd0);
      check($sformatf("rd_post%0d_busy", c), 32'(busy), 32'd0);
    end
    run_vec(11, v_after_reset);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
